// File: rtl/alu_mdu_iter_if.sv
// alu_mdu_iter_if: operand/result handshake bundle for the iterative ALU/MDU
interface alu_mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: ALU with iterative shift-add multiply and restoring divide; ALU_MDU_SIGNED_EN adds signed mulh/mulhsu/div/rem
module alu_mdu_iter #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst_n,
    alu_mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [4:0]       op_q;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc, mq, md, result_q;
    logic             neg_q, dbz_q;
    logic             accept, last, in_ready, out_valid;
    logic             sa, sb, a_neg, b_neg, neg_nxt, ge;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res, a_mag, b_mag, acc_step, mq_step, diff, quo, rem_v, fin_res;
    logic [WIDTH:0]   sum, shifted;
    logic [2*WIDTH-1:0] prod;

    function automatic logic op_mul(input logic [4:0] o);
`ifdef ALU_MDU_SIGNED_EN
        return o inside {5'd11, 5'd12, 5'd16, 5'd17};
`else
        return o inside {5'd11, 5'd12};
`endif
    endfunction

    function automatic logic op_div(input logic [4:0] o);
`ifdef ALU_MDU_SIGNED_EN
        return o inside {5'd13, 5'd14, 5'd18, 5'd19};
`else
        return o inside {5'd13, 5'd14};
`endif
    endfunction

    function automatic logic op_rem(input logic [4:0] o);
        return o inside {5'd14, 5'd19};
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                if (bus.in_valid) state_nxt = (op_mul(bus.op) || op_div(bus.op)) ? BUSY : DONE;
            end
            BUSY: if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // single-cycle ops and operand magnitudes/sign fix-up decided at accept
    always_comb begin
        shamt = bus.b[SHW-1:0];
`ifdef ALU_MDU_SIGNED_EN
        sa = bus.op inside {5'd16, 5'd17, 5'd18, 5'd19};
        sb = bus.op inside {5'd16, 5'd18, 5'd19};
`else
        sa = 1'b0;
        sb = 1'b0;
`endif
        a_neg = sa & bus.a[WIDTH-1];
        b_neg = sb & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
        // a zero divisor keeps the all-ones quotient unnegated; remainder follows the dividend
        neg_nxt = !op_div(bus.op) ? a_neg ^ b_neg :
                  op_rem(bus.op)  ? a_neg : (a_neg ^ b_neg) & (bus.b != '0);
        simple_res = '0;
        case (bus.op)
            5'd0:    simple_res = bus.a + bus.b;
            5'd1:    simple_res = bus.a - bus.b;
            5'd2:    simple_res = bus.b;
            5'd3:    simple_res = bus.a & bus.b;
            5'd4:    simple_res = bus.a ^ bus.b;
            5'd5:    simple_res = bus.a | bus.b;
            5'd6:    simple_res = bus.a << shamt;
            5'd7:    simple_res = bus.a >> shamt;
            5'd8:    simple_res = $unsigned($signed(bus.a) >>> shamt);
            5'd9:    simple_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            5'd10:   simple_res = WIDTH'(bus.a < bus.b);
            default: simple_res = '0;
        endcase
    end

    // one multiply or divide step, and the final result with sign applied
    always_comb begin
        sum      = {1'b0, acc} + (mq[0] ? {1'b0, md} : '0);
        shifted  = {acc, mq[WIDTH-1]};
        ge       = shifted >= {1'b0, md};
        diff     = shifted[WIDTH-1:0] - md;
        acc_step = op_mul(op_q) ? sum[WIDTH:1] : (ge ? diff : shifted[WIDTH-1:0]);
        mq_step  = op_mul(op_q) ? {sum[0], mq[WIDTH-1:1]} : {mq[WIDTH-2:0], ge};
        prod     = neg_q ? -{acc_step, mq_step} : {acc_step, mq_step};
        quo      = neg_q ? -mq_step : mq_step;
        rem_v    = neg_q ? -acc_step : acc_step;
        fin_res  = op_mul(op_q) ? (op_q == 5'd11 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]) :
                   op_rem(op_q) ? rem_v : quo;
        last     = cnt == (SHW+1)'(1);
    end

    // operand capture, iteration registers and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            md       <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.op;
            neg_q <= neg_nxt;
            acc   <= '0;
            mq    <= a_mag;
            md    <= b_mag;
            dbz_q <= 1'b0;
            cnt   <= (op_mul(bus.op) || op_div(bus.op)) ? (SHW+1)'(WIDTH) : '0;
            if (!(op_mul(bus.op) || op_div(bus.op))) result_q <= simple_res;
        end else if (state == BUSY) begin
            acc <= acc_step;
            mq  <= mq_step;
            cnt <= cnt - 1'b1;
            if (last) begin
                result_q <= fin_res;
                dbz_q    <= op_div(op_q) && md == '0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_mdu_iter.md
Name: alu_mdu_iter

Overview:
- Parametrised-width successor to the combinational integer ALU.
- Adds a registered valid/ready interface, plus iterative multiply and divide (one bit per cycle) alongside all base ALU operations.
- Sits in the EX stage. The pipeline stalls while in_ready or out_valid is low.

Parameters:
- WIDTH, 32: operand and result width. Must be a power of two and at least 8.
- SHW, $clog2(WIDTH): number of low B bits used as the shift amount. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op, a and b are valid this cycle.
- in_ready  output  1  block can accept an operation.
- op  input  5  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result.
- div_by_zero  output  1  flag, valid with result.

Behaviour:
- Op encoding, 0-10, same meaning as the base ALU:
  - 0 add, 1 sub, 2 lui (pass b), 3 and, 4 xor, 5 or, 6 sll, 7 srl, 8 sra.
  - 9 slt (signed), 10 sltu (unsigned). Both return 1 or 0, zero-extended.
- Op encoding, new ops:
  - 11 mul: low WIDTH bits of the product.
  - 12 mulhu: high WIDTH bits of the unsigned product.
  - 13 divu, 14 remu.
  - 15-31 reserved: treated as simple ops with result 0.
- Shifts use only b[SHW-1:0]. Shift amounts of WIDTH or more are not possible.
- Arithmetic wraps modulo 2^WIDTH. No overflow flag.
- State machine with states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. When in_valid is high, capture op, a and b.
    - Simple op: compute and register the result, go to DONE.
    - mul or div op: load the working registers, set the counter to WIDTH, go to BUSY.
  - BUSY: in_ready=0. Perform one shift-add (mul) or one restoring-subtract (div) step per cycle and decrement the counter. When the counter reaches 0, write the result and go to DONE.
  - DONE: out_valid=1, and result and div_by_zero are held stable. When out_ready is high, go to IDLE next cycle. out_valid is low in that cycle.
- Latency, measured from the accept edge N:
  - Simple op: out_valid is high from cycle N+1.
  - mul or div op: out_valid is high from cycle N+1+WIDTH.
- Back-to-back throughput: one simple op per 2 cycles; one mul or div op per WIDTH+2 cycles.
- Divide by zero (b==0):
  - divu returns all ones; remu returns a.
  - div_by_zero=1. Still takes the full WIDTH cycles, so latency is uniform.
- div_by_zero is 0 for every op other than divu and remu with b==0.
- in_valid is ignored outside IDLE. Operands are sampled only on accept, so a and b may change afterwards.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, counter=0.
- Reset asserted mid-operation aborts immediately. No result is produced, and after reset is released the first operation behaves normally.
- out_ready may be held high continuously; this gives no combinational path from out_ready to in_ready.

Optional Feature:
- Macro: ALU_MDU_SIGNED_EN.
- Defined, adds ops 16-19:
  - 16 mulh: signed x signed, high half. 17 mulhsu: signed a x unsigned b, high half.
  - 18 div, 19 rem: signed, truncating toward zero. Remainder takes the sign of the dividend.
  - Implemented by taking magnitudes, using the unsigned datapath, then fixing the sign. Latency is the same as the unsigned ops.
  - Divide by zero: div returns all ones, rem returns a, div_by_zero=1.
  - Overflow case MIN / -1: div returns MIN, rem returns 0, div_by_zero=0.
- Undefined: ops 16-19 are reserved, result 0, simple-op latency.

Test Plan (WIDTH=32):
- Simple ops:
  - add with a=0xFFFFFFFF, b=1 -> result 0 at N+1.
  - sra with a=0x80000000, b=0x24 -> shift amount 4, result 0xF8000000.
  - slt with a=-1, b=1 -> 1. sltu with the same operands -> 0.
- mul:
  - a=0x12345678, b=0x9ABCDEF0 -> mul result 0x242D2080.
  - mulhu, same operands -> 0x0B00EA4E.
  - Both: out_valid first high at N+33.
- divu and remu:
  - a=100, b=7 -> divu 14, remu 2.
  - a=5, b=0 -> divu 0xFFFFFFFF, remu 5, div_by_zero=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles after out_valid rises -> result stable, in_ready=0, new in_valid ignored.
  - Raise out_ready -> IDLE next cycle, then the next op is accepted.
- Reset mid-op: assert rst_n=0 at BUSY cycle 10 of a divu -> outputs go to reset values with no clock edge. After release, add 2+3 -> 5 at N+1.
- With ALU_MDU_SIGNED_EN:
  - div a=-7, b=2 -> -3; rem -> -1.
  - div a=0x80000000, b=-1 -> 0x80000000; rem -> 0.
  - mulh a=-1, b=-1 -> 0.
